// File: rtl/gate_cmd_rx_pkg.sv
// Shared definitions for the gate command path: command words, control
// encodings and the serial receiver state type.
package gate_pkg;

  localparam logic [31:0] CMD_GO_HIGH = 32'd1;
  localparam logic [31:0] CMD_GO_LOW  = 32'd2;

  localparam logic [2:0] CTRL_STOP = 3'b001;
  localparam logic [2:0] CTRL_HIGH = 3'b010;
  localparam logic [2:0] CTRL_LOW  = 3'b100;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/gate_cmd_rx_uart_byte_rx.sv
// 8N1 byte receiver: two-flop synchroniser, mid-bit sampling FSM and the
// bit-timing counters. Byte results are flagged in the stop-bit sample cycle.
module uart_byte_rx
  import gate_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       stop_err,
  output logic       rx_idle,
  output logic       start_det
);

  localparam int H     = CLKS_PER_BIT / 2;
  localparam int LAST  = H + 9 * CLKS_PER_BIT;
  localparam int CW    = $clog2(LAST + 1);
  localparam logic [CW-1:0] H_C     = CW'(H);
  localparam logic [CW-1:0] BIT_C   = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST8_C = CW'(H + 8 * CLKS_PER_BIT);
  localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};

  rx_state_e     state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] bit_ctr_q, bit_ctr_d;
  logic [CW-1:0] smp_pt_q, smp_pt_d;
  logic [7:0]    shift_q, shift_d;
  logic          rxs;
  logic          smp_now;

  assign rxs       = sync_q[1];
  assign byte_data = shift_q;
  assign rx_idle   = (state_q == RX_IDLE);

  // Next-state logic; bit_ctr holds the cycle index since the start-edge cycle.
  always_comb begin
    sync_d     = {sync_q[0], rxd};
    state_d    = state_q;
    bit_ctr_d  = bit_ctr_q;
    smp_pt_d   = smp_pt_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    stop_err   = 1'b0;
    start_det  = 1'b0;
    smp_now    = (bit_ctr_q == smp_pt_q);
    case (state_q)
      RX_IDLE: begin
        if (!rxs) begin
          state_d   = RX_START;
          start_det = 1'b1;
          bit_ctr_d = ONE_C;
          smp_pt_d  = H_C;
        end else begin
          bit_ctr_d = {CW{1'b0}};
        end
      end
      RX_START: begin
        bit_ctr_d = bit_ctr_q + ONE_C;
        if (smp_now) begin
          smp_pt_d = smp_pt_q + BIT_C;
          state_d  = rxs ? RX_IDLE : RX_DATA;
        end else begin
          state_d = RX_START;
        end
      end
      RX_DATA: begin
        bit_ctr_d = bit_ctr_q + ONE_C;
        if (smp_now) begin
          shift_d  = {rxs, shift_q[7:1]};
          smp_pt_d = smp_pt_q + BIT_C;
          state_d  = (smp_pt_q == LAST8_C) ? RX_STOP : RX_DATA;
        end else begin
          state_d = RX_DATA;
        end
      end
      RX_STOP: begin
        bit_ctr_d = bit_ctr_q + ONE_C;
        if (smp_now) begin
          state_d    = RX_IDLE;
          byte_valid = rxs;
          stop_err   = !rxs;
        end else begin
          state_d = RX_STOP;
        end
      end
      default: begin
        state_d   = RX_IDLE;
        bit_ctr_d = {CW{1'b0}};
      end
    endcase
  end

  // Receiver state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RX_IDLE;
      sync_q    <= 2'b11;
      bit_ctr_q <= {CW{1'b0}};
      smp_pt_q  <= {CW{1'b0}};
      shift_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      bit_ctr_q <= bit_ctr_d;
      smp_pt_q  <= smp_pt_d;
      shift_q   <= shift_d;
    end
  end

endmodule

// File: rtl/gate_cmd_rx.sv
// Command receiver for the gate controller: assembles four serial bytes
// (LSB first) into a word, strobes tx, and flags bad stop bits or stalls.
module gate_cmd_rx
  import gate_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  output logic        tx,
  output logic [31:0] dataIn,
  output logic        frameErr
);

  localparam int GAP_MAX = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int GW      = $clog2(GAP_MAX + 1);
  localparam logic [GW-1:0] GAP_MAX_C = GW'(GAP_MAX);
  localparam logic [GW-1:0] GAP_ONE_C = {{(GW-1){1'b0}}, 1'b1};

  logic          byte_valid, stop_err, rx_idle, start_det;
  logic [7:0]    byte_data;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [GW-1:0] gap_ctr_q, gap_ctr_d;
  logic [31:0]   word_q, word_d;
  logic [31:0]   data_q, data_d;
  logic          tx_q, tx_d;
  logic          fe_q, fe_d;
  logic          timeout;

  uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .stop_err   (stop_err),
    .rx_idle    (rx_idle),
    .start_det  (start_det)
  );

  assign tx       = tx_q;
  assign dataIn   = data_q;
  assign frameErr = fe_q;

  // Word assembly and inter-byte timeout; an expiring timeout takes
  // priority over a start edge seen in the same cycle.
  always_comb begin
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    gap_ctr_d  = gap_ctr_q;
    data_d     = data_q;
    tx_d       = 1'b0;
    fe_d       = 1'b0;
    timeout    = rx_idle && (byte_cnt_q != 2'd0) && (gap_ctr_q == GAP_MAX_C);
    if (timeout || stop_err) begin
      fe_d       = 1'b1;
      byte_cnt_d = 2'd0;
      gap_ctr_d  = {GW{1'b0}};
      word_d     = 32'h0000_0000;
    end else if (byte_valid) begin
      gap_ctr_d = {GW{1'b0}};
      case (byte_cnt_q)
        2'd0:    word_d[7:0]   = byte_data;
        2'd1:    word_d[15:8]  = byte_data;
        2'd2:    word_d[23:16] = byte_data;
        default: word_d[31:24] = byte_data;
      endcase
      if (byte_cnt_q == 2'd3) begin
        data_d     = {byte_data, word_q[23:0]};
        tx_d       = 1'b1;
        byte_cnt_d = 2'd0;
      end else begin
        byte_cnt_d = byte_cnt_q + 2'd1;
      end
    end else if (start_det) begin
      gap_ctr_d = {GW{1'b0}};
    end else if (rx_idle && (byte_cnt_q != 2'd0)) begin
      gap_ctr_d = gap_ctr_q + GAP_ONE_C;
    end else begin
      gap_ctr_d = gap_ctr_q;
    end
  end

  // Assembler and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q     <= 32'h0000_0000;
      byte_cnt_q <= 2'd0;
      gap_ctr_q  <= {GW{1'b0}};
      data_q     <= 32'h0000_0000;
      tx_q       <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
      gap_ctr_q  <= gap_ctr_d;
      data_q     <= data_d;
      tx_q       <= tx_d;
      fe_q       <= fe_d;
    end
  end

endmodule

// File: tb/tb_gate_cmd_rx.sv
// Directed bench for gate_cmd_rx: table of clean words plus hand-written
// sequences for stop errors, timeout, glitches and mid-word reset.
module tb_gate_cmd_rx;
  import gate_pkg::*;

  localparam int C   = 16;
  localparam int H   = C / 2;
  localparam int TOB = 20;
  // Cycles from driving a start bit until tx/frameErr is seen: two
  // synchroniser stages, the stop sample at H+9C, then the output register.
  localparam int TX_LAT  = 2 + H + 9 * C + 1;
  localparam int TO_LAT  = TX_LAT + 1 + TOB * C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxd = 1'b1;
  logic        tx;
  logic [31:0] dataIn;
  logic        frameErr;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int tx_cnt = 0, fe_cnt = 0, last_tx_cyc = 0, last_fe_cyc = 0;
  int hold_err = 0, both_err = 0;
  int last_start = 0;
  logic [31:0] last_tx_data = 32'h0;
  logic [31:0] prev_data = 32'h0;
  logic        rst_prev = 1'b1;

  typedef struct packed {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  b3;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [6];

  gate_cmd_rx #(.CLKS_PER_BIT(C), .TIMEOUT_BITS(TOB)) dut (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .tx       (tx),
    .dataIn   (dataIn),
    .frameErr (frameErr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_prev <= rst;
  end

  always @(negedge clk) begin
    if (tx) begin
      tx_cnt++;
      last_tx_cyc  = cyc;
      last_tx_data = dataIn;
    end
    if (frameErr) begin
      fe_cnt++;
      last_fe_cyc = cyc;
    end
    if (tx && frameErr) both_err++;
    if (!tx && !rst_prev && (dataIn !== prev_data)) hold_err++;
    prev_data = dataIn;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_events();
    tx_cnt = 0;
    fe_cnt = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    last_start = cyc;
    rxd = 1'b0;
    idle(C);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      idle(C);
    end
    rxd = stop_bit;
    idle(C);
    rxd = 1'b1;
  endtask

  task automatic send_word(input logic [7:0] b0, b1, b2, b3);
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b1);
    send_byte(b2, 1'b1);
    send_byte(b3, 1'b1);
  endtask

  initial begin
    int s;
    vecs[0] = '{8'h01, 8'h00, 8'h00, 8'h00, 32'h0000_0001};
    vecs[1] = '{8'h02, 8'h00, 8'h00, 8'h00, 32'h0000_0002};
    vecs[2] = '{8'hAB, 8'hCD, 8'hEF, 8'h12, 32'h12EF_CDAB};
    vecs[3] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFF_FFFF};
    vecs[4] = '{8'h00, 8'h00, 8'h00, 8'h80, 32'h8000_0000};
    vecs[5] = '{8'h5A, 8'hA5, 8'h3C, 8'hC3, 32'hC33C_A55A};

    idle(3);
    check("reset_tx", {31'h0, tx}, 32'h0);
    check("reset_dataIn", dataIn, 32'h0);
    check("reset_frameErr", {31'h0, frameErr}, 32'h0);
    rst = 1'b0;
    idle(10);

    // Clean words, back-to-back bytes.
    for (int i = 0; i < 6; i++) begin
      clear_events();
      send_word(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3);
      idle(4);
      check("vec_tx_count", tx_cnt, 32'd1);
      check("vec_latency", last_tx_cyc - last_start, TX_LAT);
      check("vec_dataIn", last_tx_data, vecs[i].exp);
      check("vec_frameErr_count", fe_cnt, 32'd0);
      idle(20);
      check("vec_dataIn_hold", dataIn, vecs[i].exp);
    end

    // Bad stop bit on the second byte, then a clean word.
    clear_events();
    send_byte(8'h01, 1'b1);
    send_byte(8'h55, 1'b0);
    s = last_start;
    idle(40);
    check("stoperr_fe_count", fe_cnt, 32'd1);
    check("stoperr_fe_cycle", last_fe_cyc - s, TX_LAT);
    check("stoperr_tx_count", tx_cnt, 32'd0);
    send_word(8'h01, 8'h00, 8'h00, 8'h00);
    idle(4);
    check("stoperr_next_tx", tx_cnt, 32'd1);
    check("stoperr_next_data", last_tx_data, 32'h0000_0001);
    check("stoperr_fe_total", fe_cnt, 32'd1);

    // Two bytes, then the line stays idle past the timeout.
    idle(20);
    clear_events();
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    s = last_start;
    idle(TO_LAT - 10 * C + 10);
    check("timeout_fe_count", fe_cnt, 32'd1);
    check("timeout_fe_cycle", last_fe_cyc - s, TO_LAT);
    check("timeout_tx_count", tx_cnt, 32'd0);
    send_word(8'h02, 8'h00, 8'h00, 8'h00);
    idle(4);
    check("timeout_next_tx", tx_cnt, 32'd1);
    check("timeout_next_data", last_tx_data, 32'h0000_0002);
    check("timeout_fe_total", fe_cnt, 32'd1);

    // Short low glitch shorter than half a bit.
    idle(20);
    clear_events();
    rxd = 1'b0;
    idle(5);
    rxd = 1'b1;
    idle(30);
    check("glitch_tx_count", tx_cnt, 32'd0);
    check("glitch_fe_count", fe_cnt, 32'd0);
    check("glitch_state_idle", {30'h0, dut.u_rx.state_q}, {30'h0, RX_IDLE});

    // Reset in the middle of the third byte.
    clear_events();
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    rxd = 1'b0;
    idle(C);
    rxd = 1'b1;
    idle(3 * C);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("midrst_tx", {31'h0, tx}, 32'h0);
    check("midrst_dataIn", dataIn, 32'h0);
    check("midrst_frameErr", {31'h0, frameErr}, 32'h0);
    idle(30);
    send_word(8'h01, 8'h00, 8'h00, 8'h00);
    idle(4);
    check("midrst_next_tx", tx_cnt, 32'd1);
    check("midrst_next_data", last_tx_data, 32'h0000_0001);
    check("midrst_fe_count", fe_cnt, 32'd0);

    check("dataIn_hold_violations", hold_err, 32'd0);
    check("tx_and_frameErr_together", both_err, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
